// File: rtl/bfm_apbtoahb_pkg.sv
// Shared definitions for the APB-to-AHB bridge BFM: FSM encodings, AHB
// transfer encodings and the address-window helper.
package bfm_apbtoahb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   localparam logic [1:0] HTRANS_IDLE     = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
   localparam logic [2:0] HSIZE_WORD      = 3'b010;
   localparam logic [2:0] HBURST_SINGLE   = 3'b000;
   localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;
   localparam logic       HRESP_OKAY      = 1'b0;
   localparam logic       HRESP_ERROR     = 1'b1;

   // Mask of the HADDR bits taken from PADDR; the rest come from the AHB base.
   function automatic logic [31:0] addr_mask(input int paddr_bits);
      logic [63:0] m;
      m = (64'd1 << paddr_bits) - 64'd1;
      return m[31:0];
   endfunction

endpackage

// File: rtl/bfm_apbtoahb_wdog.sv
// Transfer watchdog: counts AHB wait cycles of one transfer and flags the
// cycle on which the limit is reached. Built only with BFM_APBTOAHB_TIMEOUT_EN.
module bfm_apbtoahb_wdog #(
   parameter int LIMIT = 256
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic count_i,
   output logic expired_o
);

   localparam int W = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // The limit is reached on the LIMIT-th counted wait cycle.
   assign expired_o = count_i && (cnt_q == W'(LIMIT - 1));
   assign cnt_d     = clear_i ? '0 : ((count_i && !expired_o) ? cnt_q + 1'b1 : cnt_q);

   // Wait-cycle counter, cleared when a new transfer is accepted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignment for every flop, so all registers see pre-edge values.
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bfm_apbtoahb.sv
// APB-slave to AHB-Lite-master bridge BFM. Each APB transfer becomes one AHB
// SINGLE word transfer; the AHB response returns on PREADY/PSLVERR.
// Optional macro BFM_APBTOAHB_TIMEOUT_EN adds a wait-state watchdog that
// aborts a transfer after TIMEOUT_CYCLES HREADY-low cycles with PSLVERR=1.
// TPD documents the output delay of the behavioural BFM set; the synthesizable
// outputs here are plain registers.
module bfm_apbtoahb
   import bfm_apbtoahb_pkg::*;
#(
   parameter int          TPD            = 1,
   parameter int          PADDR_BITS     = 24,
   parameter logic [31:0] AHB_BASE       = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 256
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic        HMASTLOCK,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   localparam logic [31:0] ADDR_MASK = addr_mask(PADDR_BITS);

   // An illegal configuration elaborates this otherwise empty marker block.
   if (PADDR_BITS < 2 || PADDR_BITS > 32 || TPD < 0 || TIMEOUT_CYCLES < 1) begin : g_illegal_params
   end

   state_e      state_q;
   logic [31:0] haddr_q;
   logic [1:0]  htrans_q;
   logic        hwrite_q;
   logic [31:0] wdata_q;
   logic [31:0] hwdata_q;
   logic [31:0] prdata_q;
   logic        pready_q;
   logic        pslverr_q;

   logic        setup;
   logic [31:0] haddr_d;
   logic        wd_expired;

   assign setup   = PSEL && !PENABLE;
   // Upper bits from the AHB window, lower bits from PADDR, always word aligned.
   assign haddr_d = (AHB_BASE & ~ADDR_MASK) | (PADDR & ADDR_MASK & 32'hFFFF_FFFC);

`ifdef BFM_APBTOAHB_TIMEOUT_EN
   logic wd_clear;
   logic wd_count;

   assign wd_clear = (state_q == ST_IDLE) && setup;
   assign wd_count = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && !HREADY;

   bfm_apbtoahb_wdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk_i     (HCLK),
      .rst_i     (HRESET),
      .clear_i   (wd_clear),
      .count_i   (wd_count),
      .expired_o (wd_expired)
   );
`else
   assign wd_expired = 1'b0;
`endif

   // Transfer FSM with all bus outputs registered.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q   <= ST_IDLE;
         haddr_q   <= '0;
         htrans_q  <= HTRANS_IDLE;
         hwrite_q  <= 1'b0;
         wdata_q   <= '0;
         hwdata_q  <= '0;
         prdata_q  <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // An access phase without a preceding setup phase is ignored.
               if (setup) begin
                  haddr_q  <= haddr_d;
                  hwrite_q <= PWRITE;
                  wdata_q  <= PWDATA;
                  htrans_q <= HTRANS_NONSEQ;
                  state_q  <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (wd_expired) begin
                  htrans_q  <= HTRANS_IDLE;
                  pready_q  <= 1'b1;
                  pslverr_q <= 1'b1;
                  state_q   <= ST_RESP;
               end else if (HREADY) begin
                  htrans_q <= HTRANS_IDLE;
                  hwdata_q <= wdata_q;
                  state_q  <= ST_DATA;
               end
            end
            ST_DATA: begin
               // The first cycle of a two-cycle ERROR response is just a wait state.
               if (wd_expired) begin
                  pready_q  <= 1'b1;
                  pslverr_q <= 1'b1;
                  state_q   <= ST_RESP;
               end else if (HREADY) begin
                  pslverr_q <= (HRESP == HRESP_ERROR);
                  if (!hwrite_q) begin
                     prdata_q <= HRDATA;
                  end
                  pready_q  <= 1'b1;
                  state_q   <= ST_RESP;
               end
            end
            ST_RESP: begin
               // Response is presented for one cycle whether or not PSEL is still high.
               pready_q  <= 1'b0;
               pslverr_q <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign PRDATA    = prdata_q;
   assign PREADY    = pready_q;
   assign PSLVERR   = pslverr_q;
   assign HADDR     = haddr_q;
   assign HTRANS    = htrans_q;
   assign HWRITE    = hwrite_q;
   assign HWDATA    = hwdata_q;
   assign HSIZE     = HSIZE_WORD;
   assign HBURST    = HBURST_SINGLE;
   assign HPROT     = HPROT_DATA_PRIV;
   assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_bfm_apbtoahb.sv
// Self-checking bench for bfm_apbtoahb: directed APB transfers against a
// scripted AHB slave; APB responses are checked by a scoreboard monitor.
module tb_bfm_apbtoahb;

   localparam logic [31:0] BASE = 32'h4000_0000;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic        PSEL = 1'b0;
   logic        PENABLE = 1'b0;
   logic        PWRITE = 1'b0;
   logic [31:0] PADDR = '0;
   logic [31:0] PWDATA = '0;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA = '0;
   logic        HREADY = 1'b1;
   logic        HRESP = 1'b0;

   bfm_apbtoahb #(
      .TPD            (1),
      .PADDR_BITS     (24),
      .AHB_BASE       (BASE),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HBURST    (HBURST),
      .HPROT     (HPROT),
      .HMASTLOCK (HMASTLOCK),
      .HWDATA    (HWDATA),
      .HRDATA    (HRDATA),
      .HREADY    (HREADY),
      .HRESP     (HRESP)
   );

   always #5 HCLK = ~HCLK;

   typedef struct packed {
      logic [31:0] prdata;
      logic        err;
   } resp_t;

   resp_t       exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] last_rd = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every PREADY pulse consumes one expected response.
   always @(negedge HCLK) begin
      resp_t e;
      if (!HRESET && PREADY === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_pready: got PREADY=1, want no response (t=%0t)", $time);
         end else begin
            e = exp_q.pop_front();
            check("resp_prdata", PRDATA, e.prdata);
            check("resp_pslverr", 32'(PSLVERR), 32'(e.err));
         end
      end
   end

   // One APB transfer with 'waits' AHB data-phase wait states. Called at a negedge.
   task automatic xfer(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                       input int waits, input logic [31:0] rdata, input logic err,
                       input logic [31:0] exp_haddr, input logic drop_psel);
      resp_t e;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = addr; PWDATA = wdata;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
      e.prdata = w ? last_rd : rdata;
      e.err    = err;
      exp_q.push_back(e);
      if (!w) last_rd = rdata;
      @(posedge HCLK); #1;              // cycle 1: address phase
      PENABLE = 1'b1;
      if (drop_psel) begin PSEL = 1'b0; PENABLE = 1'b0; end
      @(negedge HCLK);
      check("htrans_nonseq", 32'(HTRANS), 32'(2'b10));
      check("haddr", HADDR, exp_haddr);
      check("hwrite", 32'(HWRITE), 32'(w));
      @(posedge HCLK); #1;              // cycle 2: first data-phase cycle
      for (int i = 0; i <= waits; i++) begin
         HREADY = (i == waits);
         HRESP  = err && (i >= waits - 1);
         HRDATA = (i == waits) ? rdata : 32'h0;
         if (i == 0) begin
            @(negedge HCLK);
            check("htrans_idle_data", 32'(HTRANS), 32'(2'b00));
            if (w) check("hwdata", HWDATA, wdata);
         end
         @(posedge HCLK); #1;
      end
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
      @(negedge HCLK);
      check("pready_latency", 32'(PREADY), 32'd1);
      @(posedge HCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge HCLK);
      check("pready_single", 32'(PREADY), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1, "bench timeout");
   end

   initial begin
      // Reset values and constant outputs.
      repeat (2) @(negedge HCLK);
      check("rst_htrans", 32'(HTRANS), 32'd0);
      check("rst_haddr", HADDR, 32'd0);
      check("rst_hwrite", 32'(HWRITE), 32'd0);
      check("rst_hwdata", HWDATA, 32'd0);
      check("rst_prdata", PRDATA, 32'd0);
      check("rst_pready", 32'(PREADY), 32'd0);
      check("rst_pslverr", 32'(PSLVERR), 32'd0);
      check("hsize", 32'(HSIZE), 32'd2);
      check("hburst", 32'(HBURST), 32'd0);
      check("hprot", 32'(HPROT), 32'd3);
      check("hmastlock", 32'(HMASTLOCK), 32'd0);
      HRESET = 1'b0;
      @(negedge HCLK);

      // Zero-wait write, 3-wait read, write leaving PRDATA alone, upper PADDR bits dropped.
      xfer(1'b1, 32'h0012_3456, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 32'h4012_3454, 1'b0);
      xfer(1'b0, 32'h0000_0010, 32'h0,         3, 32'hCAFE_0001, 1'b0, 32'h4000_0010, 1'b0);
      xfer(1'b1, 32'hFF00_0ABF, 32'h1234_5678, 0, 32'h0, 1'b0, 32'h4000_0ABC, 1'b0);

      // Two-cycle ERROR response, then a clean transfer.
      xfer(1'b0, 32'h0000_0020, 32'h0,         1, 32'hBAD0_0BAD, 1'b1, 32'h4000_0020, 1'b0);
      xfer(1'b1, 32'h0000_0024, 32'h0F0F_0F0F, 2, 32'h0, 1'b0, 32'h4000_0024, 1'b0);

      // Access phase without setup in IDLE: no AHB activity.
      PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h0000_0100;
      for (int i = 0; i < 3; i++) begin
         @(negedge HCLK);
         check("no_setup_idle", 32'(HTRANS), 32'd0);
      end
      PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge HCLK);
      check("no_setup_idle_after", 32'(HTRANS), 32'd0);

      // PSEL dropped after the setup phase: the transfer still completes once.
      xfer(1'b0, 32'h0000_0044, 32'h0, 1, 32'h5555_AAAA, 1'b0, 32'h4000_0044, 1'b1);
      @(negedge HCLK);
      check("drop_psel_idle", 32'(HTRANS), 32'd0);

      // Reset mid data phase with HREADY low.
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0000_0100; PWDATA = 32'hA5A5_A5A5;
      @(posedge HCLK); #1;
      PENABLE = 1'b1; HREADY = 1'b1;
      @(posedge HCLK); #1;
      HREADY = 1'b0;
      @(negedge HCLK);
      check("pre_rst_hwdata", HWDATA, 32'hA5A5_A5A5);
      #2 HRESET = 1'b1;
      #1;
      check("rst_mid_htrans", 32'(HTRANS), 32'd0);
      check("rst_mid_pready", 32'(PREADY), 32'd0);
      check("rst_mid_hwdata", HWDATA, 32'd0);
      check("rst_mid_haddr", HADDR, 32'd0);
      PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1;
      last_rd = '0;
      @(negedge HCLK);
      HRESET = 1'b0;
      @(negedge HCLK);
      check("post_rst_idle", 32'(HTRANS), 32'd0);
      check("post_rst_pready", 32'(PREADY), 32'd0);
      xfer(1'b0, 32'h0000_0008, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 32'h4000_0008, 1'b0);

`ifdef BFM_APBTOAHB_TIMEOUT_EN
      // Watchdog abort after 8 HREADY-low cycles; late HREADY is ignored.
      begin
         resp_t e;
         int    n;
         e.prdata = last_rd;
         e.err    = 1'b1;
         exp_q.push_back(e);
         PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0000_0300;
         @(posedge HCLK); #1;
         PENABLE = 1'b1; HREADY = 1'b0;
         @(negedge HCLK);
         check("to_nonseq", 32'(HTRANS), 32'(2'b10));
         n = 1;
         while (PREADY !== 1'b1 && n < 20) begin
            @(negedge HCLK);
            n++;
         end
         check("to_cycle", 32'(n), 32'd9);
         check("to_htrans_idle", 32'(HTRANS), 32'd0);
         @(posedge HCLK); #1;
         PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1; HRESP = 1'b1; HRDATA = 32'hFFFF_FFFF;
         for (int i = 0; i < 2; i++) begin
            @(negedge HCLK);
            check("to_late_pready", 32'(PREADY), 32'd0);
            check("to_late_htrans", 32'(HTRANS), 32'd0);
         end
         HRESP = 1'b0; HRDATA = '0;
         @(negedge HCLK);
         xfer(1'b1, 32'h0000_0304, 32'h7777_0000, 0, 32'h0, 1'b0, 32'h4000_0304, 1'b0);
      end
`endif

      repeat (2) @(negedge HCLK);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
